// File: rtl/syn_pcm_mem_pkg.sv
// Shared constants and types for the ping-pong PCM sample buffer.
// Holds the default geometry, the frame-end address and the bank-select type.
package syn_pcm_mem_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 7;

    // The frame-end address at the default geometry (all ones).
    localparam logic [ADDR_W_DEF-1:0] LAST_ADDR = '1;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/syn_pcm_bank.sv
// Simple dual-port RAM: one write port and one registered, enabled read port.
// The memory array is never reset; only the read register is.
module syn_pcm_bank #(
    parameter int WIDTH   = 64,
    parameter int DEPTH_W = 7
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_en,
    input  logic [DEPTH_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    input  logic               i_rd_en,
    input  logic [DEPTH_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]   o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_W];
    logic [WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register only loads on an enabled read, so it holds otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/syn_pcm_mem.sv
// Ping-pong PCM frame buffer: Acortex fills the write bank, Fgyrus drains the other.
// Writing the last address swaps banks and raises pcm_data_rdy until the frame is consumed.
module syn_pcm_mem
    import syn_pcm_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_ir,
    input  logic              rst_il,
    input  logic [ADDR_W-1:0] pcm_addr,
    input  logic [DATA_W-1:0] lpcm_wdata,
    input  logic [DATA_W-1:0] rpcm_wdata,
    input  logic              pcm_wren,
    input  logic              pcm_rden,
    output logic [DATA_W-1:0] lpcm_rdata,
    output logic [DATA_W-1:0] rpcm_rdata,
    output logic              pcm_rd_valid,
    output logic              pcm_data_rdy
);

    localparam logic [ADDR_W-1:0] FRAME_END = '1;

    bank_sel_t r_wr_bank;
    bank_sel_t r_rd_bank;
    logic      r_rd_valid;
    logic      r_data_rdy;

    logic              w_wr;
    logic              w_rd;
    logic              w_last;
    logic              w_frame_done;
    logic              w_consume;
    bank_sel_t         w_rd_src;
    logic [2*DATA_W-1:0] w_wdata;
    logic [2*DATA_W-1:0] w_rdata0;
    logic [2*DATA_W-1:0] w_rdata1;

    // The shared address bus gives the write side priority; a colliding read is dropped.
    assign w_wr         = pcm_wren;
    assign w_rd         = pcm_rden & ~pcm_wren;
    assign w_last       = (pcm_addr == FRAME_END);
    assign w_frame_done = w_wr & w_last;
    assign w_consume    = w_rd & w_last;
    assign w_rd_src     = other_bank(r_wr_bank);
    assign w_wdata      = {lpcm_wdata, rpcm_wdata};

    syn_pcm_bank #(
        .WIDTH   (2*DATA_W),
        .DEPTH_W (ADDR_W)
    ) u_bank0 (
        .i_clk     (clk_ir),
        .i_rst_n   (rst_il),
        .i_wr_en   (w_wr & (r_wr_bank == BANK0)),
        .i_wr_addr (pcm_addr),
        .i_wr_data (w_wdata),
        .i_rd_en   (w_rd & (w_rd_src == BANK0)),
        .i_rd_addr (pcm_addr),
        .o_rd_data (w_rdata0)
    );

    syn_pcm_bank #(
        .WIDTH   (2*DATA_W),
        .DEPTH_W (ADDR_W)
    ) u_bank1 (
        .i_clk     (clk_ir),
        .i_rst_n   (rst_il),
        .i_wr_en   (w_wr & (r_wr_bank == BANK1)),
        .i_wr_addr (pcm_addr),
        .i_wr_data (w_wdata),
        .i_rd_en   (w_rd & (w_rd_src == BANK1)),
        .i_rd_addr (pcm_addr),
        .o_rd_data (w_rdata1)
    );

    // The read bank is sampled before any swap, so a read always names the frame it was issued against.
    always_ff @(posedge clk_ir or negedge rst_il) begin
        if (!rst_il) begin
            r_wr_bank  <= BANK0;
            r_rd_bank  <= BANK1;
            r_rd_valid <= 1'b0;
            r_data_rdy <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_bank <= w_rd_src;
            end
            if (w_frame_done) begin
                r_wr_bank <= other_bank(r_wr_bank);
            end
            if (w_frame_done) begin
                r_data_rdy <= 1'b1;
            end else if (w_consume) begin
                r_data_rdy <= 1'b0;
            end
        end
    end

    // Both bank read registers hold, so muxing by the last-read bank keeps rdata stable.
    assign {lpcm_rdata, rpcm_rdata} = (r_rd_bank == BANK1) ? w_rdata1 : w_rdata0;
    assign pcm_rd_valid = r_rd_valid;
    assign pcm_data_rdy = r_data_rdy;

endmodule

// File: tb/tb_syn_pcm_mem.sv
// Randomized bench for syn_pcm_mem against a frame-level reference model of the two banks.
// Every cycle checks rd_valid, data_rdy and (when the model knows it) the read data.
module tb_syn_pcm_mem;
    import syn_pcm_mem_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk_ir = 1'b0;
    logic          rst_il = 1'b0;
    logic [AW-1:0] pcm_addr = '0;
    logic [DW-1:0] lpcm_wdata = '0;
    logic [DW-1:0] rpcm_wdata = '0;
    logic          pcm_wren = 1'b0;
    logic          pcm_rden = 1'b0;
    logic [DW-1:0] lpcm_rdata;
    logic [DW-1:0] rpcm_rdata;
    logic          pcm_rd_valid;
    logic          pcm_data_rdy;

    syn_pcm_mem #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_ir       (clk_ir),
        .rst_il       (rst_il),
        .pcm_addr     (pcm_addr),
        .lpcm_wdata   (lpcm_wdata),
        .rpcm_wdata   (rpcm_wdata),
        .pcm_wren     (pcm_wren),
        .pcm_rden     (pcm_rden),
        .lpcm_rdata   (lpcm_rdata),
        .rpcm_rdata   (rpcm_rdata),
        .pcm_rd_valid (pcm_rd_valid),
        .pcm_data_rdy (pcm_data_rdy)
    );

    always #5 clk_ir = ~clk_ir;

    // Reference model: two banks of {L,R} pairs, which bank Acortex is filling,
    // whether an unread frame is waiting, and what the consumer last received.
    logic [2*DW-1:0] m_mem   [2][DEPTH];
    bit              m_known [2][DEPTH];
    int              m_fill_bank;
    bit              m_rdy;
    bit              m_valid;
    logic [2*DW-1:0] m_rdata;
    bit              m_rdata_known;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill_bank   = 0;
        m_rdy         = 1'b0;
        m_valid       = 1'b0;
        m_rdata       = '0;
        m_rdata_known = 1'b1;
    endtask

    // One clock: drive on the falling edge, update the model, check 1 time unit after the rising edge.
    task automatic cycle(input bit wren, input bit rden, input int addr,
                         input logic [DW-1:0] l, input logic [DW-1:0] r);
        @(negedge clk_ir);
        pcm_wren   = wren;
        pcm_rden   = rden;
        pcm_addr   = AW'(addr);
        lpcm_wdata = l;
        rpcm_wdata = r;
        if (wren) begin
            m_mem[m_fill_bank][addr]   = {l, r};
            m_known[m_fill_bank][addr] = 1'b1;
            m_valid = 1'b0;
            if (addr == DEPTH - 1) begin
                m_fill_bank = 1 - m_fill_bank;
                m_rdy       = 1'b1;
            end
        end else if (rden) begin
            m_valid       = 1'b1;
            m_rdata       = m_mem[1 - m_fill_bank][addr];
            m_rdata_known = m_known[1 - m_fill_bank][addr];
            if (addr == DEPTH - 1) m_rdy = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk_ir);
        #1;
        check("rd_valid", 64'(pcm_rd_valid), 64'(m_valid));
        check("data_rdy", 64'(pcm_data_rdy), 64'(m_rdy));
        if (m_rdata_known) check("rdata", {lpcm_rdata, rpcm_rdata}, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, '0, '0);
    endtask

    // Reset asserted between clock edges must clear the outputs without waiting for a clock.
    task automatic do_reset();
        @(posedge clk_ir);
        #2;
        rst_il   = 1'b0;
        pcm_wren = 1'b0;
        pcm_rden = 1'b0;
        #1;
        check("rst_rdata", {lpcm_rdata, rpcm_rdata}, 64'd0);
        check("rst_valid", 64'(pcm_rd_valid), 64'd0);
        check("rst_rdy", 64'(pcm_data_rdy), 64'd0);
        @(negedge clk_ir);
        @(negedge clk_ir);
        rst_il = 1'b1;
        model_reset();
    endtask

    task automatic write_frame(input logic [DW-1:0] base_l, input logic [DW-1:0] base_r);
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, a, base_l + DW'(a), base_r + DW'(a));
    endtask

    task automatic read_frame();
        for (int a = 0; a < DEPTH; a++) cycle(1'b0, 1'b1, a, '0, '0);
    endtask

    initial begin
        int ra;
        int wa;
        model_reset();
        do_reset();
        idle(2);

        // Frame A, then read it back while frame B fills the other bank.
        write_frame(32'h1000_0000, 32'h2000_0000);
        ra = 0;
        wa = 0;
        while (ra < DEPTH || wa < DEPTH - 1) begin
            if (wa < DEPTH - 1 && (ra >= DEPTH || $urandom_range(0, 1) == 1)) begin
                cycle(1'b1, 1'b0, wa, 32'hB000_0000 + DW'(wa), 32'hB100_0000 + DW'(wa));
                wa++;
            end else begin
                cycle(1'b0, 1'b1, ra, '0, '0);
                ra++;
            end
        end
        cycle(1'b1, 1'b0, DEPTH - 1, 32'hB000_0000 + DW'(DEPTH - 1), 32'hB100_0000 + DW'(DEPTH - 1));
        for (int i = 0; i < 150; i++) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, DEPTH - 2), '0, '0);
        end
        read_frame();

        // Collision: the write lands, the read is dropped.
        cycle(1'b0, 1'b1, 9, '0, '0);
        cycle(1'b1, 1'b1, 5, 32'hC011_1111, 32'hC022_2222);
        for (int a = 0; a < DEPTH; a++) begin
            if (a != 5) cycle(1'b1, 1'b0, a, 32'h5000_0000 + DW'(a), 32'h6000_0000 + DW'(a));
        end
        cycle(1'b0, 1'b1, 5, '0, '0);
        read_frame();

        // Free-running traffic with frequent frame-end addresses and collisions.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
                  ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, DEPTH - 1),
                  $urandom, $urandom);
        end
        read_frame();

        // Overrun: frame D replaces unread frame C.
        write_frame(32'hC000_0000, 32'hC100_0000);
        write_frame(32'hD000_0000, 32'hD100_0000);
        idle(2);
        read_frame();

        // Partial frame abandoned by reset, then a clean frame E.
        for (int a = 0; a < DEPTH / 2; a++) cycle(1'b1, 1'b0, a, 32'hF000_0000 + DW'(a), 32'hF100_0000 + DW'(a));
        do_reset();
        idle(1);
        write_frame(32'hE000_0000, 32'hE100_0000);
        read_frame();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/syn_pcm_mem.md
Name: syn_pcm_mem

Overview:
- Ping-pong PCM sample buffer between Acortex (producer) and Fgyrus (consumer).
- Acortex writes one frame of left/right sample pairs into the write bank.
- When the frame's last address is written, the banks swap and pcm_data_rdy tells Fgyrus a full frame is ready to read.
- Both sides share one address bus, so the read and write sides time-share pcm_addr.

Parameters:
- DATA_W, 32, width of each PCM sample (left and right separately).
- ADDR_W, 7, frame address width; a frame holds 2^ADDR_W sample pairs per bank.

Ports:
- clk_ir  input  1  system clock, all logic on the rising edge.
- rst_il  input  1  reset, asynchronous, active-low.
- pcm_addr  input  ADDR_W  shared sample address for both write and read.
- lpcm_wdata  input  DATA_W  left-channel write sample.
- rpcm_wdata  input  DATA_W  right-channel write sample.
- pcm_wren  input  1  write strobe (Acortex side).
- pcm_rden  input  1  read strobe (Fgyrus side).
- lpcm_rdata  output  DATA_W  left-channel read sample.
- rpcm_rdata  output  DATA_W  right-channel read sample.
- pcm_rd_valid  output  1  one-cycle qualifier for the read data.
- pcm_data_rdy  output  1  level flag: the read bank holds an unconsumed full frame.

Behaviour:
- Interface: one clock, clk_ir; reset rst_il is asynchronous and active-low.
- Reset values:
  - lpcm_rdata = 0, rpcm_rdata = 0.
  - pcm_rd_valid = 0, pcm_data_rdy = 0.
  - Bank select wr_bank = 0, so the read bank is 1.
  - RAM contents are not reset.
- Storage: two banks (0/1); each bank holds an L and an R array of 2^ADDR_W x DATA_W.
- Write:
  - Any cycle with pcm_wren=1 stores lpcm_wdata/rpcm_wdata at pcm_addr in bank wr_bank.
  - Write order is free; any address may be rewritten.
- Frame completion:
  - A write with pcm_addr = 2^ADDR_W-1 (all ones) completes the frame.
  - On the next edge, wr_bank toggles and pcm_data_rdy is set to 1.
- Read:
  - A cycle with pcm_rden=1 and pcm_wren=0 reads pcm_addr from bank ~wr_bank.
  - The bank used is the one selected before any swap in that same cycle.
  - Latency is one clock: on the following edge lpcm_rdata/rpcm_rdata update and pcm_rd_valid=1 for exactly one cycle.
  - Back-to-back reads give back-to-back valids.
- Hold: with no read, pcm_rd_valid=0 and rdata holds its last value.
- Consume:
  - An accepted read of address 2^ADDR_W-1 clears pcm_data_rdy on the same edge that pcm_rd_valid asserts.
  - That clear happens only if no frame completes in that cycle.
- Collision: pcm_wren and pcm_rden together means the write takes priority. The read is dropped with no pcm_rd_valid and no rdata change.
- Reads while pcm_data_rdy=0 are serviced normally; the data is stale or undefined, and this is the consumer's responsibility.
- Overrun: a frame that completes while pcm_data_rdy=1 still swaps banks, and pcm_data_rdy stays 1. The newest frame wins and the unread frame is overwritten on later writes.
- Set/clear priority: frame completion and a consume in the same cycle cannot coincide because of the collision rule. If they ever did, set wins.
- Reset mid-frame:
  - Partial writes are abandoned and wr_bank returns to 0.
  - pcm_data_rdy clears.
  - The next full frame behaves normally.

Decomposition:
- Package syn_pcm_mem_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the LAST_ADDR constant (all ones);
  - a bank-select typedef.
- Sub-module syn_pcm_bank: a simple dual-port RAM with one write port, one registered read port and parameterized width/depth. Instantiate two per channel pair, or one per bank with L/R concatenated to 2*DATA_W.
- Top-level syn_pcm_mem contains:
  - bank-select register;
  - rdy flag;
  - rd_valid pipeline;
  - collision and priority logic.

Test Plan:
- Reset: assert rst_il=0 mid-clock -> all outputs 0 immediately (asynchronous); after release pcm_data_rdy=0.
- Full frame: write addr 0..127 with L=0x1000_0000+addr, R=0x2000_0000+addr -> pcm_data_rdy=1 the edge after the addr-127 write. Read 0..127 back-to-back -> each rd_valid one cycle after rden; rdata matches; rdy drops with the addr-127 data.
- Ping-pong: while reading frame A, interleave writes of frame B (L=0xB000_0000+addr) on cycles without rden -> frame A reads stay intact; after B completes, rdy=1 and reads return frame B.
- Collision: wren=1 and rden=1 same cycle at addr 5 -> write stored, no rd_valid, rdata unchanged.
- Overrun: complete two frames (C then D) without any read -> rdy stays 1; reading returns frame D values.
- Reset mid-frame: write addr 0..63, pulse rst_il low, then write a full frame E -> rdy rises only after addr 127 of E; reads return E data.
